morse_disp_sequencer: RTL and testbench

//  Paces decoded Morse letters onto the VGA letter display. Buffers letters from the decoder in a small

---
 rtl/morse_disp_pkg.sv | 24 ++
 rtl/morse_disp_if.sv | 23 ++
 rtl/morse_disp_fifo.sv | 57 +++++
 rtl/morse_disp_sequencer.sv | 117 +++++++++++
 tb/tb_morse_disp_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_disp_pkg.sv
// Shared constants and types for the Morse letter display sequencer.
// Holds the default letter width, the blank code and the FSM state encoding.
package morse_disp_pkg;

  localparam int LETTER_W_DEF = 6;
  localparam int BLANK_CODE = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/morse_disp_if.sv
// Letter handshake from the Morse decoder into the display sequencer.
// master: decoder (drives in_valid/in_letter); slave: sequencer (drives in_ready).
interface morse_disp_if #(
  parameter int LETTER_W = morse_disp_pkg::LETTER_W_DEF
);

  logic                in_valid;
  logic [LETTER_W-1:0] in_letter;
  logic                in_ready;

  modport master (
    output in_valid,
    output in_letter,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_letter,
    output in_ready
  );

endinterface

// File: rtl/morse_disp_fifo.sv
// Small synchronous letter FIFO with first-word fall-through head.
// Ports: clk, reset, push/din, pop, flush, head, full, level.
module morse_disp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot.
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/morse_disp_sequencer.sv
// Paces decoded Morse letters onto the VGA letter display (show, then gap).
// Ports: clk, reset, in_if (slave handshake), clear, vgaon, lett, busy, level.
// Option: DISP_HOLD_LAST_EN keeps the last letter lit when nothing is queued.
module morse_disp_sequencer
  import morse_disp_pkg::*;
#(
  parameter int LETTER_W    = LETTER_W_DEF,
  parameter int DEPTH       = 8,
  parameter int SHOW_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  morse_disp_if.slave                in_if,
  input  logic                       clear,
  output logic                       vgaon,
  output logic [LETTER_W-1:0]        lett,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int CW =
    $clog2(max3(SHOW_CYCLES, GAP_CYCLES, 2));

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [LETTER_W-1:0] head;
  logic                full;
  logic                cnt_zero;
  logic                take;
  logic                pop;
  logic                hold_end;

  morse_disp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LETTER_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.in_valid && !clear),
    .din   (in_if.in_letter),
    .pop   (pop),
    .flush (clear),
    .head  (head),
    .full  (full),
    .level (level)
  );

  assign in_if.in_ready = !full;
  assign busy     = (state != ST_IDLE) || (level != '0);
  assign cnt_zero = (cnt == '0);

`ifdef DISP_HOLD_LAST_EN
  assign hold_end = (level == '0);
`else
  assign hold_end = 1'b0;
`endif

  // IDLE only loads a letter once the display is dark, so a held
  // letter gets one blank edge before its replacement appears.
  always_comb begin
    take = 1'b0;
    case (state)
      ST_IDLE: take = !vgaon;
      ST_SHOW: take = cnt_zero && (GAP_CYCLES == 0);
      ST_GAP:  take = cnt_zero;
      default: take = 1'b0;
    endcase
  end

  assign pop = take && (level != '0) && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      vgaon <= 1'b0;
      lett  <= LETTER_W'(BLANK_CODE);
    end else if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
      vgaon <= 1'b0;
      lett  <= LETTER_W'(BLANK_CODE);
    end else if (pop) begin
      state <= ST_SHOW;
      cnt   <= CW'(SHOW_CYCLES - 1);
      vgaon <= 1'b1;
      lett  <= head;
    end else begin
      case (state)
        ST_IDLE: begin
          if (level != '0) vgaon <= 1'b0;
        end
        ST_SHOW: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (hold_end) begin
            state <= ST_IDLE;
          end else if (GAP_CYCLES > 0) begin
            vgaon <= 1'b0;
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= ST_GAP;
          end else begin
            vgaon <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
          else           state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_disp_sequencer.sv
// Self-checking bench for morse_disp_sequencer (DEPTH=4, SHOW=5, GAP=2).
// A second instance uses GAP_CYCLES=0 for back-to-back display.
module tb_morse_disp_sequencer;

  localparam int LW = 6;
`ifdef DISP_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic          v;
    logic [LW-1:0] l;
    logic          on;
    logic [LW-1:0] lt;
    logic [2:0]    lvl;
    logic          rdy;
    logic          bsy;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear_a = 1'b0;
  logic          clear_b = 1'b0;
  logic          vgaon_a, vgaon_b;
  logic          busy_a, busy_b;
  logic [LW-1:0] lett_a, lett_b;
  logic [2:0]    level_a, level_b;

  int errs = 0;
  int checks = 0;
  bit rec = 1'b0;
  logic          rec_on [$];
  logic [LW-1:0] rec_lt [$];

  morse_disp_if #(.LETTER_W(LW)) if_a ();
  morse_disp_if #(.LETTER_W(LW)) if_b ();

  always #5 clk = ~clk;

  morse_disp_sequencer #(
    .LETTER_W(LW), .DEPTH(4),
    .SHOW_CYCLES(5), .GAP_CYCLES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .in_if(if_a),
    .clear(clear_a), .vgaon(vgaon_a),
    .lett(lett_a), .busy(busy_a), .level(level_a)
  );

  morse_disp_sequencer #(
    .LETTER_W(LW), .DEPTH(4),
    .SHOW_CYCLES(5), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .in_if(if_b),
    .clear(clear_b), .vgaon(vgaon_b),
    .lett(lett_b), .busy(busy_b), .level(level_b)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rec) begin
      rec_on.push_back(vgaon_a);
      rec_lt.push_back(lett_a);
    end
  endtask

  task automatic mid_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    chk({tag, "_vgaon"}, vgaon_a, 0);
    chk({tag, "_lett"}, lett_a, 0);
    chk({tag, "_level"}, level_a, 0);
    chk({tag, "_ready"}, if_a.in_ready, 1);
    chk({tag, "_busy"}, busy_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Splits recorded vgaon into runs: letter order, completed
  // high-run lengths and low-run lengths between letters.
  task automatic analyze(
    input string nm,
    input int    exp_l [$],
    input int    hi,
    input int    lo
  );
    int   got [$];
    int   run;
    int   low;
    bit   seen;
    logic prev;
    run = 0; low = 0; seen = 0; prev = 1'b0;
    for (int i = 0; i < rec_on.size(); i++) begin
      if (rec_on[i]) begin
        if (!prev) begin
          got.push_back(int'(rec_lt[i]));
          if (seen) chk({nm, "_gap"}, low, lo);
          run = 0;
        end
        run++;
      end else begin
        if (prev) begin
          chk({nm, "_show"}, run, hi);
          seen = 1;
          low = 0;
        end
        low++;
      end
      prev = rec_on[i];
    end
    chk({nm, "_count"}, got.size(), exp_l.size());
    for (int i = 0; i < got.size() && i < exp_l.size(); i++)
      chk($sformatf("%s_lett%0d", nm, i), got[i], exp_l[i]);
  endtask

  task automatic push5();
    for (int i = 1; i <= 5; i++) begin
      if_a.in_valid = 1'b1;
      if_a.in_letter = LW'(i);
      chk($sformatf("push%0d_rdy", i), if_a.in_ready, 1);
      tick();
    end
    if_a.in_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl [9];
    bit   found;
    int   hi_cnt;

    if_a.in_valid = 1'b0;
    if_a.in_letter = '0;
    if_b.in_valid = 1'b0;
    if_b.in_letter = '0;

    tbl[0] = '{1'b1, 6'd7, 1'b0, 6'd0, 3'd1, 1'b1, 1'b1};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{1'b0, 6'd0, 1'b1, 6'd7, 3'd0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 6'd0, HOLD, 6'd7, 3'd0, 1'b1, !HOLD};
    tbl[7] = '{1'b0, 6'd0, HOLD, 6'd7, 3'd0, 1'b1, !HOLD};
    tbl[8] = '{1'b0, 6'd0, HOLD, 6'd7, 3'd0, 1'b1, 1'b0};

    mid_reset("rst0");

    for (int i = 0; i < 9; i++) begin
      if_a.in_valid = tbl[i].v;
      if_a.in_letter = tbl[i].l;
      tick();
      chk($sformatf("t%0d_vgaon", i), vgaon_a, tbl[i].on);
      chk($sformatf("t%0d_lett", i), lett_a, tbl[i].lt);
      chk($sformatf("t%0d_level", i), level_a, tbl[i].lvl);
      chk($sformatf("t%0d_ready", i), if_a.in_ready, tbl[i].rdy);
      chk($sformatf("t%0d_busy", i), busy_a, tbl[i].bsy);
    end
    if_a.in_valid = 1'b0;

    mid_reset("rst1");
    rec = 1'b1;
    push5();
    chk("full_level", level_a, 4);
    chk("full_ready", if_a.in_ready, 0);
    if_a.in_valid = 1'b1;
    if_a.in_letter = 6'd6;
    tick();
    if_a.in_valid = 1'b0;
    chk("refused_level", level_a, 4);
    for (int i = 0; i < 34; i++) tick();
    rec = 1'b0;
    analyze("seq", '{1, 2, 3, 4, 5}, 5, 2);

    mid_reset("rst2");
    push5();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (vgaon_a && lett_a == 6'd3) found = 1'b1;
      else tick();
    end
    chk("wait_lett3", found, 1);
    chk("clr_pre_level", level_a, 2);
    clear_a = 1'b1;
    if_a.in_valid = 1'b1;
    if_a.in_letter = 6'd9;
    chk("clr_ready", if_a.in_ready, 1);
    tick();
    clear_a = 1'b0;
    if_a.in_valid = 1'b0;
    chk("clr_vgaon", vgaon_a, 0);
    chk("clr_lett", lett_a, 0);
    chk("clr_level", level_a, 0);
    chk("clr_busy", busy_a, 0);
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vgaon_a) hi_cnt++;
    end
    chk("clr_quiet", hi_cnt, 0);

    if_a.in_valid = 1'b1;
    if_a.in_letter = 6'd5;
    tick();
    if_a.in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_vgaon", vgaon_a, 1);
    mid_reset("rst3");

    if_b.in_valid = 1'b1;
    if_b.in_letter = 6'd9;
    tick();
    chk("g0_e0_vgaon", vgaon_b, 0);
    chk("g0_e0_level", level_b, 1);
    if_b.in_letter = 6'd10;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if_b.in_valid = 1'b0;
      chk($sformatf("g0_e%0d_vgaon", k), vgaon_b, 1);
      chk($sformatf("g0_e%0d_lett", k), lett_b,
          (k <= 5) ? 9 : 10);
    end
    tick();
    chk("g0_end_vgaon", vgaon_b, HOLD);
    chk("g0_end_lett", lett_b, 10);
    chk("g0_end_level", level_b, 0);

`ifdef DISP_HOLD_LAST_EN
    mid_reset("rst4");
    if_a.in_valid = 1'b1;
    if_a.in_letter = 6'd12;
    tick();
    if_a.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("hold_vgaon", vgaon_a, 1);
    chk("hold_lett", lett_a, 12);
    chk("hold_busy", busy_a, 0);
    if_a.in_valid = 1'b1;
    if_a.in_letter = 6'd13;
    tick();
    if_a.in_valid = 1'b0;
    chk("hold_push_vgaon", vgaon_a, 1);
    chk("hold_push_level", level_a, 1);
    tick();
    chk("hold_flash_vgaon", vgaon_a, 0);
    tick();
    chk("hold_new_vgaon", vgaon_a, 1);
    chk("hold_new_lett", lett_a, 13);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
